mac_accum4: RTL and testbench

Sequential multiply-accumulate back end placed directly downstream of the 4-bit array multiplier. It consumes the multiplier's 8-bit product through a valid/ready handshake and sums a fixed-length frame of LEN products. It then presents the frame total on a held output handshake, so dot products of 4-bit vectors can be built from the combinational multiplier.

---
 rtl/mac_accum4.sv | 103 ++++++++++
 tb/tb_mac_accum4.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mac_accum4.sv
// Frame accumulator behind the 4x4 array multiplier: sums LEN 8-bit products
// per frame and presents the total on a held valid/ready output.
module mac_accum4 #(
    parameter int unsigned LEN   = 4,
    parameter int unsigned ACC_W = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       p,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             clr,
    output logic [ACC_W-1:0] sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [4:0]       terms
);

    localparam int unsigned TERMS_W = 5;
    localparam logic [TERMS_W-1:0] LAST_TERM = TERMS_W'(LEN - 1);

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t              state, state_nx;
    logic [ACC_W-1:0]    acc, acc_nx;
    logic [ACC_W-1:0]    sum_nx;
    logic [TERMS_W-1:0]  terms_nx;
    logic                out_valid_nx;
    logic [ACC_W-1:0]    p_ext;

    assign p_ext = ACC_W'(p);

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_ACC;
            acc       <= '0;
            sum       <= '0;
            terms     <= '0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nx;
            acc       <= acc_nx;
            sum       <= sum_nx;
            terms     <= terms_nx;
            out_valid <= out_valid_nx;
        end
    end

    // Next-state, datapath update and in_ready; in_ready never depends on in_valid
    always_comb begin
        state_nx     = state;
        acc_nx       = acc;
        sum_nx       = sum;
        terms_nx     = terms;
        out_valid_nx = out_valid;
        in_ready     = 1'b0;

        if (clr) begin
            state_nx     = ST_ACC;
            acc_nx       = '0;
            terms_nx     = '0;
            out_valid_nx = 1'b0;
        end else begin
            unique case (state)
                ST_ACC: begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        if (terms == LAST_TERM) begin
                            sum_nx       = acc + p_ext;
                            acc_nx       = '0;
                            terms_nx     = '0;
                            out_valid_nx = 1'b1;
                            state_nx     = ST_HOLD;
                        end else begin
                            acc_nx   = acc + p_ext;
                            terms_nx = terms + TERMS_W'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    in_ready = out_ready;
                    if (out_ready) begin
                        out_valid_nx = 1'b0;
                        state_nx     = ST_ACC;
                        // LEN >= 2, so a product taken here can never close a frame
                        if (in_valid) begin
                            acc_nx   = p_ext;
                            terms_nx = TERMS_W'(1);
                        end
                    end
                end
                default: begin
                    state_nx = ST_ACC;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_accum4.sv
// Self-checking bench for mac_accum4: directed scenarios plus randomized
// dot-product frames against a frame-level reference model.
module tb_mac_accum4;

    localparam int unsigned LEN   = 4;
    localparam int unsigned ACC_W = 10;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [7:0]       p = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             clr = 1'b0;
    logic [ACC_W-1:0] sum;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [4:0]       terms;

    mac_accum4 #(.LEN(LEN), .ACC_W(ACC_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .p         (p),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .clr       (clr),
        .sum       (sum),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .terms     (terms)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference: products of the open frame, completed-frame total, held flag
    int frame_q[$];
    int m_sum  = 0;
    bit m_hold = 1'b0;
    bit last_acc = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        frame_q.delete();
        m_hold = 1'b0;
        m_sum  = 0;
    endtask

    // One clock: drive inputs, check in_ready, advance the model, check outputs
    task automatic cycle(input logic v, input logic [7:0] pv, input logic ordy, input logic c);
        int s;
        in_valid  = v;
        p         = pv;
        out_ready = ordy;
        clr       = c;
        #1;
        check("in_ready", 32'(in_ready), 32'(!c && (!m_hold || ordy)));
        last_acc = v && !c && (!m_hold || ordy);
        if (c) begin
            frame_q.delete();
            m_hold = 1'b0;
        end else begin
            if (m_hold && ordy) m_hold = 1'b0;
            if (last_acc) begin
                frame_q.push_back(int'(pv));
                if (frame_q.size() == LEN) begin
                    s = 0;
                    foreach (frame_q[i]) s += frame_q[i];
                    m_sum  = s;
                    m_hold = 1'b1;
                    frame_q.delete();
                end
            end
        end
        @(posedge clk);
        #1;
        check("out_valid", 32'(out_valid), 32'(m_hold));
        check("terms", 32'(terms), 32'(frame_q.size()));
        check("sum", 32'(sum), 32'(m_sum));
    endtask

    task automatic idle(input logic ordy);
        cycle(1'b0, 8'd0, ordy, 1'b0);
    endtask

    int a_v, b_v, pend, cur_dot, cur_n, frames_done, cyc;
    bit have, v_r, ordy_r;
    int dot_q[$];
    logic [7:0] vec[4];

    initial begin
        // Reset
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_terms", 32'(terms), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        rst_n = 1'b1;
        model_reset();
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Max products back to back
        repeat (4) cycle(1'b1, 8'd225, 1'b1, 1'b0);
        check("t1_sum", 32'(sum), 32'd900);
        check("t1_valid", 32'(out_valid), 32'd1);
        idle(1'b1);

        // Gapped input
        vec = '{8'd3, 8'd10, 8'd0, 8'd7};
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, vec[i], 1'b1, 1'b0);
            if (i < 3) begin
                check("t2_terms", 32'(terms), 32'(i + 1));
                idle(1'b1);
                idle(1'b1);
            end
        end
        check("t2_sum", 32'(sum), 32'd20);
        idle(1'b1);

        // Back-pressure with a pending product
        for (int i = 1; i <= 4; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
        repeat (5) begin
            cycle(1'b1, 8'd9, 1'b0, 1'b0);
            check("t3_held_sum", 32'(sum), 32'd10);
        end
        cycle(1'b1, 8'd9, 1'b1, 1'b0);
        check("t3_accept9_terms", 32'(terms), 32'd1);
        repeat (3) cycle(1'b1, 8'd1, 1'b1, 1'b0);
        check("t3_sum", 32'(sum), 32'd12);
        idle(1'b1);

        // clr mid-frame, blocked product 99
        cycle(1'b1, 8'd50, 1'b1, 1'b0);
        cycle(1'b1, 8'd60, 1'b1, 1'b0);
        cycle(1'b1, 8'd99, 1'b1, 1'b1);
        check("t4_clr_terms", 32'(terms), 32'd0);
        repeat (4) cycle(1'b1, 8'd5, 1'b1, 1'b0);
        check("t4_sum", 32'(sum), 32'd20);

        // clr while holding: result dropped, sum retained
        cycle(1'b0, 8'd0, 1'b0, 1'b1);
        check("t4b_sum_kept", 32'(sum), 32'd20);

        // Asynchronous reset between edges
        repeat (3) cycle(1'b1, 8'd77, 1'b1, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        check("t5_async_terms", 32'(terms), 32'd0);
        check("t5_async_valid", 32'(out_valid), 32'd0);
        rst_n = 1'b1;
        model_reset();
        repeat (4) cycle(1'b1, 8'd1, 1'b1, 1'b0);
        check("t5_sum", 32'(sum), 32'd4);
        idle(1'b1);

        // Random dot products through the multiplier's product
        have = 1'b0; cur_dot = 0; cur_n = 0; frames_done = 0; cyc = 0;
        while (frames_done < 1000 && cyc < 20000) begin
            if (!have) begin
                a_v  = int'($urandom_range(0, 15));
                b_v  = int'($urandom_range(0, 15));
                pend = a_v * b_v;
                have = 1'b1;
            end
            v_r    = ($urandom_range(0, 3) != 0);
            ordy_r = ($urandom_range(0, 9) < 7);
            if (out_valid && ordy_r) begin
                if (dot_q.size() == 0) check("rand_spurious_frame", 32'd1, 32'd0);
                else check("rand_frame_sum", 32'(sum), 32'(dot_q.pop_front()));
                frames_done++;
            end
            cycle(v_r, 8'(pend), ordy_r, 1'b0);
            if (last_acc) begin
                cur_dot += pend;
                cur_n++;
                have = 1'b0;
                if (cur_n == LEN) begin
                    dot_q.push_back(cur_dot);
                    cur_dot = 0;
                    cur_n   = 0;
                end
            end
            cyc++;
        end
        check("rand_frames_done", 32'(frames_done), 32'd1000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
